// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : mem_initiator
//  Description : Bus initiator for a byte-wide synchronous RAM. Accepts byte
//                or 16-bit little-endian word read/write requests from the core
//                over a valid/ready handshake and sequences them into one or
//                two RAM byte cycles. The RAM has 1-cycle read latency. Each
//                request ends with a one-cycle response pulse that carries the
//                read data.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W      address width; address arithmetic wraps modulo 2**ADDR_W
//    NARROW_SEXT 1: byte reads sign-extend into rsp_rdata[15:8]; 0: zero-extend
//  Ports
//    clk         system clock, all logic on posedge
//    rst_n       synchronous reset, active-low
//    req_valid   core request present
//    req_ready   initiator idle; request accepted when valid && ready
//    req_we      1 = write, 0 = read
//    req_wide    1 = 16-bit word, 0 = byte
//    req_adr     byte address (no alignment required)
//    req_wdata   write data; byte access uses [7:0]
//    rsp_valid   one-cycle pulse: request complete
//    rsp_rdata   read data, stable from rsp_valid until the next response
//    mem_adr     RAM address
//    mem_dat_o   write byte to RAM
//    mem_dat_i   read byte from RAM, valid the cycle after a sel && !we cycle
//    mem_sel     RAM select
//    mem_we      RAM write enable (only meaningful with mem_sel)
// ============================================================================
module mem_initiator #(
  parameter int ADDR_W      = 16,
  parameter bit NARROW_SEXT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_wide,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [7:0]        mem_dat_o,
  input  logic [7:0]        mem_dat_i,
  output logic              mem_sel,
  output logic              mem_we
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] IDLE = 3'd0;  // waiting for a request
  localparam logic [2:0] ACC0 = 3'd1;  // RAM cycle for the first byte
  localparam logic [2:0] ACC1 = 3'd2;  // RAM cycle for the second byte (wide)
  localparam logic [2:0] CAP  = 3'd3;  // read only: last byte arrives from RAM
  localparam logic [2:0] RESP = 4'd4;  // response pulse

  logic [2:0]        state;
  logic [2:0]        state_next;

  // Latched request
  logic              accept;
  logic              we_q;
  logic              wide_q;
  logic [ADDR_W-1:0] adr_q;
  logic [7:0]        wdata_hi_q;   // low byte goes straight to the bus at accept

  // First read byte of a wide read
  logic [7:0]        byte0;

  // Registered bus and response drivers plus their next values
  logic              sel_q;
  logic              mwe_q;
  logic              sel_d;
  logic              mwe_d;
  logic [ADDR_W-1:0] adr_d;
  logic [7:0]        dat_d;
  logic              rsp_valid_d;
  logic [15:0]       rdata_d;
  logic [15:0]       narrow_rdata;

  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;

  // The select and write enable are gated with rst_n so that a reset arriving
  // in the middle of a word access stops the RAM from committing the cycle that
  // is on the bus at the aborting edge.
  assign mem_sel = sel_q && rst_n;
  assign mem_we  = mwe_q && rst_n;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ACC0;
        end
      end
      ACC0: begin
        if (wide_q) begin
          state_next = ACC1;
        end else if (we_q) begin
          state_next = RESP;
        end else begin
          state_next = CAP;
        end
      end
      ACC1: begin
        state_next = we_q ? RESP : CAP;
      end
      CAP: begin
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // Bus and response outputs are registered, so their next values are decoded
  // from state_next: the values then appear during the cycle spent in that
  // state. When no RAM cycle follows, address and data hold their last value.
  // --------------------------------------------------------------------------
  assign narrow_rdata = NARROW_SEXT ? {{8{mem_dat_i[7]}}, mem_dat_i}
                                    : {8'h00, mem_dat_i};

  always_comb begin
    sel_d       = 1'b0;
    mwe_d       = 1'b0;
    adr_d       = mem_adr;
    dat_d       = mem_dat_o;
    rsp_valid_d = 1'b0;
    rdata_d     = wide_q ? {mem_dat_i, byte0} : narrow_rdata;
    case (state_next)
      ACC0: begin
        // ACC0 is reached only from IDLE on accept, so the request inputs
        // are still the live source for the first bus cycle.
        sel_d = 1'b1;
        mwe_d = req_we;
        adr_d = req_adr;
        dat_d = req_we ? req_wdata[7:0] : 8'h00;
      end
      ACC1: begin
        sel_d = 1'b1;
        mwe_d = we_q;
        adr_d = adr_q + ADDR_W'(1);   // wraps at the top of the address space
        dat_d = we_q ? wdata_hi_q : 8'h00;
      end
      RESP: begin
        rsp_valid_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      wide_q     <= 1'b0;
      adr_q      <= '0;
      wdata_hi_q <= 8'h00;
      byte0      <= 8'h00;
      sel_q      <= 1'b0;
      mwe_q      <= 1'b0;
      mem_adr    <= '0;
      mem_dat_o  <= 8'h00;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 16'h0000;
    end else begin
      if (accept) begin
        we_q       <= req_we;
        wide_q     <= req_wide;
        adr_q      <= req_adr;
        wdata_hi_q <= req_wdata[15:8];
      end

      // During ACC1 of a read, the RAM presents the byte selected in ACC0.
      if ((state == ACC1) && !we_q) begin
        byte0 <= mem_dat_i;
      end

      sel_q     <= sel_d;
      mwe_q     <= mwe_d;
      mem_adr   <= adr_d;
      mem_dat_o <= dat_d;
      rsp_valid <= rsp_valid_d;

      // CAP only occurs on reads and is always followed by RESP, so loading
      // here makes rsp_rdata valid in the RESP cycle. Writes leave it alone.
      if (state == CAP) begin
        rsp_rdata <= rdata_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_initiator
//  Description : Self-checking bench for mem_initiator. Directed requests push
//                hand-computed expected bus cycles and responses into queues;
//                a monitor on the falling edge pops and compares them. A second
//                instance with NARROW_SEXT=1 shares all inputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        req_wide = 1'b0;
  logic [15:0] req_adr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic [7:0]  mem_dat_i = 8'h00;

  logic        req_ready, rsp_valid, mem_sel, mem_we;
  logic [15:0] rsp_rdata, mem_adr;
  logic [7:0]  mem_dat_o;

  logic        req_ready_s, rsp_valid_s, mem_sel_s, mem_we_s;
  logic [15:0] rsp_rdata_s, mem_adr_s;
  logic [7:0]  mem_dat_o_s;

  always #5 clk = ~clk;

  mem_initiator #(.ADDR_W(16), .NARROW_SEXT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_wide(req_wide), .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_adr(mem_adr),
    .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i), .mem_sel(mem_sel), .mem_we(mem_we)
  );

  mem_initiator #(.ADDR_W(16), .NARROW_SEXT(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_s),
    .req_we(req_we), .req_wide(req_wide), .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_s), .rsp_rdata(rsp_rdata_s), .mem_adr(mem_adr_s),
    .mem_dat_o(mem_dat_o_s), .mem_dat_i(mem_dat_i), .mem_sel(mem_sel_s), .mem_we(mem_we_s)
  );

  // Byte-wide synchronous RAM, 1-cycle read latency
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_sel) begin
      if (mem_we) ram[mem_adr] <= mem_dat_o;
      else        mem_dat_i    <= ram[mem_adr];
    end
  end

  typedef struct { logic [15:0] adr; logic we; logic [7:0] dat; } bus_t;
  typedef struct { logic [15:0] rd; logic [15:0] rds; int lat; } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rsp_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: bus cycles and responses
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) acc_q.delete();
    else if (req_valid && req_ready) acc_q.push_back(cyc);

    if (mem_sel || mem_sel_s) begin
      if (bus_q.size() == 0) begin
        chk("unexpected_bus_cycle", {mem_adr, 7'd0, mem_we, mem_dat_o}, 32'hFFFF_FFFF);
      end else begin
        bus_t b;
        b = bus_q.pop_front();
        chk("bus_cycle", {mem_adr, 6'd0, mem_sel, mem_we, mem_dat_o},
            {b.adr, 6'd0, 1'b1, b.we, b.dat});
        chk("bus_cycle_sext", {mem_adr_s, 6'd0, mem_sel_s, mem_we_s, mem_dat_o_s},
            {b.adr, 6'd0, 1'b1, b.we, b.dat});
      end
    end else if (mem_we) begin
      chk("we_without_sel", {31'd0, mem_we}, 32'd0);
    end

    if (rsp_valid || rsp_valid_s) begin
      last_rsp_cyc = cyc;
      chk("rsp_valid_sext_aligned", {31'd0, rsp_valid_s}, {31'd0, rsp_valid});
      if (rsp_q.size() == 0 || acc_q.size() == 0) begin
        chk("unexpected_rsp", {16'd0, rsp_rdata}, 32'hFFFF_FFFF);
      end else begin
        rsp_t r;
        int   a;
        r = rsp_q.pop_front();
        a = acc_q.pop_front();
        chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, r.rd});
        chk("rsp_rdata_sext", {16'd0, rsp_rdata_s}, {16'd0, r.rds});
        chk("rsp_latency", cyc - a, r.lat);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request driver; pushes expectations once the request is seen accepted.
  // Called with inputs changed just after a rising edge.
  // --------------------------------------------------------------------------
  task automatic do_req(input logic we, input logic wide, input logic [15:0] adr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd,
                        input logic [15:0] exp_rds, input int lat, input bit hold,
                        input bit gap, input bit expect_rsp);
    bit          ok;
    bus_t        b;
    rsp_t        r;
    logic [15:0] a1;
    req_we = we; req_wide = wide; req_adr = adr; req_wdata = wdata; req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    chk("ready_sext", {31'd0, req_ready_s}, 32'd1);
    if (gap) chk("b2b_accept_cycle", cyc, last_rsp_cyc + 1);
    b.adr = adr; b.we = we; b.dat = we ? wdata[7:0] : 8'h00;
    bus_q.push_back(b);
    if (wide && expect_rsp) begin
      a1 = adr + 16'd1;
      b.adr = a1; b.we = we; b.dat = we ? wdata[15:8] : 8'h00;
      bus_q.push_back(b);
    end
    if (expect_rsp) begin
      r.rd = exp_rd; r.rds = exp_rds; r.lat = lat;
      rsp_q.push_back(r);
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
    ram[16'hFFFF] <= 8'h34;
    ram[16'h0000] <= 8'h12;
    ram[16'h0010] <= 8'h80;
    ram[16'h0201] <= 8'h11;

    // Reset held with a request pending
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_wide = 1'b1;
    req_adr = 16'hFFFF; req_wdata = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      chk("reset_ready",  {31'd0, req_ready}, 32'd0);
      chk("reset_sel",    {31'd0, mem_sel},   32'd0);
      chk("reset_rsp",    {31'd0, rsp_valid}, 32'd0);
      chk("reset_rdata",  {16'd0, rsp_rdata}, 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // Narrow write
    do_req(1'b1, 1'b0, 16'h1234, 16'h00AB, 16'h0000, 16'h0000, 2, 1'b0, 1'b0, 1'b1);
    drain();
    // Wide read across the address wrap
    do_req(1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234, 16'h1234, 4, 1'b0, 1'b0, 1'b1);
    drain();
    // Narrow read of a negative byte
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0080, 16'hFF80, 3, 1'b0, 1'b0, 1'b1);
    drain();
    // Back-to-back wide write then wide read of the same word
    do_req(1'b1, 1'b1, 16'h0300, 16'hBEEF, 16'h0080, 16'hFF80, 3, 1'b1, 1'b0, 1'b1);
    do_req(1'b0, 1'b1, 16'h0300, 16'h0000, 16'hBEEF, 16'hBEEF, 4, 1'b0, 1'b1, 1'b1);
    drain();
    // Narrow write ignores the high data byte; narrow read of a positive byte
    do_req(1'b1, 1'b0, 16'h0011, 16'h5A7F, 16'hBEEF, 16'hBEEF, 2, 1'b0, 1'b0, 1'b1);
    drain();
    do_req(1'b0, 1'b0, 16'h0011, 16'h0000, 16'h007F, 16'h007F, 3, 1'b0, 1'b0, 1'b1);
    drain();

    // Wide write aborted by reset during the second byte cycle
    do_req(1'b1, 1'b1, 16'h0200, 16'hCAFE, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_sel_in_acc1", {31'd0, mem_sel}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_sel_after", {31'd0, mem_sel},   32'd0);
    chk("abort_rsp",       {31'd0, rsp_valid}, 32'd0);
    chk("abort_rdata",     {16'd0, rsp_rdata}, 32'd0);
    chk("abort_ready",     {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drain();
    chk("abort_ram_0200", {24'd0, ram[16'h0200]}, 32'h0000_00FE);
    chk("abort_ram_0201", {24'd0, ram[16'h0201]}, 32'h0000_0011);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    chk("bus_queue_empty", bus_q.size(), 32'd0);
    chk("rsp_queue_empty", rsp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
